// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
//   loader_state_t : top-level loader FSM states
//   SYNC_BYTE      : default frame sync byte
//   ERR_*          : bit positions inside the sticky err vector
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    LEN_HI,
    LEN_LO,
    DATA,
    DONE
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
  localparam int unsigned ERR_FRAMING  = 0;
  localparam int unsigned ERR_OVERFLOW = 1;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clk, rst_n : core clock, synchronous active-low reset
//   rx         : asynchronous serial input, idle high
//   rx_byte    : received byte, valid while rx_valid is high
//   rx_valid   : one-cycle pulse for a byte with a good stop bit
//   frame_err  : one-cycle pulse when the stop bit samples low (byte dropped)
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  rx_state_t         state_q, state_d;
  logic              sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a program image received over UART into the instruction RAM.
// Frame: SYNC, LEN_HI, LEN_LO (word count N), then N 32-bit words MSB first.
//   clk, rst_n          : core clock, synchronous active-low reset
//   uart_rx             : serial input, idle high
//   start               : one-cycle arm pulse, honoured in IDLE or DONE
//   mem_wren/addr/wdata : instruction RAM write port
//   cpu_rst_n           : CPU reset, released the cycle after entering DONE
//   busy / done         : loader in WAIT_SYNC..DATA / in DONE
//   err                 : sticky {overflow, framing}, cleared by start
module imem_uart_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ADDR_W = 11,
  parameter logic [7:0]  SYNC   = SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              start,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned DEPTH        = 32'd1 << ADDR_W;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (uart_rx),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  loader_state_t     state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [15:0]       len_q, len_d;
  logic [23:0]       shift_q, shift_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        err_q, err_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic [15:0]       len_new;
  logic              in_busy;

  assign in_busy = (state_q == WAIT_SYNC) || (state_q == LEN_HI) ||
                   (state_q == LEN_LO)    || (state_q == DATA);
  assign len_new = {len_q[15:8], rx_byte};

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    len_d       = len_q;
    shift_d     = shift_q;
    wren_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    cpu_rst_n_d = (state_q == DONE) && !start;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = WAIT_SYNC;
          err_d      = '0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          addr_d     = '0;
        end
      end
      WAIT_SYNC: if (rx_valid && rx_byte == SYNC) state_d = LEN_HI;
      LEN_HI: begin
        if (rx_valid) begin
          len_d   = {rx_byte, 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_d      = len_new;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          state_d    = (len_new == 16'd0) ? DONE : DATA;
          if (32'(len_new) > DEPTH) err_d[ERR_OVERFLOW] = 1'b1;
        end
      end
      DATA: begin
        if (rx_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Words beyond the RAM depth are consumed but never written.
            if (32'(word_cnt_q) < DEPTH) begin
              wren_d  = 1'b1;
              addr_d  = word_cnt_q[ADDR_W-1:0];
              wdata_d = {shift_q, rx_byte};
            end
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == len_q) state_d = DONE;
          end else begin
            shift_d = {shift_q[15:0], rx_byte};
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_err && in_busy) begin
      err_d[ERR_FRAMING] = 1'b1;
      state_d            = WAIT_SYNC;
      word_cnt_d         = '0;
      byte_cnt_d         = '0;
      addr_d             = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      len_q       <= '0;
      shift_q     <= '0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      shift_q     <= shift_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign mem_wren  = wren_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = in_busy;
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule
